// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared helpers for the FIFO round-robin arbiter.
//                - idx_width : width of a requester index ($clog2(NUM_REQ))
//                - cnt_width : width of the burst beat counter
//                              ($clog2(MAX_BURST+1))
//                - rr_inc    : modulo-N increment used to start the
//                              round-robin scan after the last winner
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Index width for a set of n requesters.
    function automatic int idx_width(input int n);
        return $clog2(n);
    endfunction

    // Counter width able to hold the values 0..b.
    function automatic int cnt_width(input int b);
        return $clog2(b + 1);
    endfunction

    // ptr + 1 modulo n; the last index wraps back to 0.
    function automatic int rr_inc(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_picker
//  Description : Combinational rotating-priority picker. Scans the request
//                vector starting at index `start`, wrapping modulo NUM_REQ,
//                and returns the first asserted request.
//  Ports       : req         in  NUM_REQ  request vector
//                start       in  IDX_W    first index examined
//                grant_oh    out NUM_REQ  one-hot grant (zero if no request)
//                grant_idx   out IDX_W    index of the granted request
//                grant_valid out 1        a request was found
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]              req,
    input  logic [idx_width(NUM_REQ)-1:0]   start,
    output logic [NUM_REQ-1:0]              grant_oh,
    output logic [idx_width(NUM_REQ)-1:0]   grant_idx,
    output logic                            grant_valid
);

    localparam int IDX_W = idx_width(NUM_REQ);

    // One extra bit so start + offset cannot overflow before the wrap.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        pos         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, start} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            pos = sum[IDX_W-1:0];
            if (!grant_valid && req[pos]) begin
                grant_valid   = 1'b1;
                grant_idx     = pos;
                grant_oh[pos] = 1'b1;
            end
        end
    end

endmodule : rr_priority_picker
`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rr_arbiter
//  Description : Round-robin merge of NUM_REQ Avalon-ST producers into one
//                registered beat stream feeding a FIFO write port. One
//                requester is granted per beat; the output register reloads
//                whenever it is empty or being drained, giving full
//                throughput.
//  Build macro : FIFO_ARB_BURST_LOCK_EN - when defined, a winner keeps the
//                grant for up to MAX_BURST consecutive beats while it stays
//                valid. When undefined, every beat is arbitrated afresh and
//                MAX_BURST has no effect.
//  Ports       : clk_i    in  1                   rising-edge clock
//                rst_n_i  in  1                   async active-low reset
//                data_i   in  NUM_REQ*DATA_WIDTH  packed requester data
//                valid_i  in  NUM_REQ             per-requester valid
//                ready_o  out NUM_REQ             per-requester ready (<=1 hot)
//                data_o   out DATA_WIDTH          registered beat
//                valid_o  out 1                   data_o holds a beat
//                ready_i  in  1                   FIFO ready
//                src_o    out $clog2(NUM_REQ)     requester that supplied data_o
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_i,
    input  logic [NUM_REQ-1:0]              valid_i,
    output logic [NUM_REQ-1:0]              ready_o,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [idx_width(NUM_REQ)-1:0]   src_o
);

    localparam int IDX_W = idx_width(NUM_REQ);

    // Unsupported configurations leave a visibly named scope behind.
    if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_unsupported_params
    end

    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_data[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   scan_start;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic               grant_valid;
    logic               load_en;
    logic               xfer;

    // The output register may take a new beat when empty or being drained.
    assign load_en    = !valid_o || ready_i;
    assign scan_start = IDX_W'(rr_inc(32'(rr_ptr), NUM_REQ));

    rr_priority_picker #(
        .NUM_REQ     (NUM_REQ)
    ) u_picker (
        .req         (valid_i),
        .start       (scan_start),
        .grant_oh    (pick_oh),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

`ifdef FIFO_ARB_BURST_LOCK_EN
    localparam int CNT_W = cnt_width(MAX_BURST);

    logic [IDX_W-1:0] owner;
    logic             locked;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             hold_owner;

    // A locked owner that is still valid bypasses the round-robin scan.
    assign hold_owner  = locked && valid_i[owner];
    assign grant_idx   = hold_owner ? owner : pick_idx;
    assign grant_oh    = hold_owner ? (NUM_REQ'(1) << owner) : pick_oh;
    assign grant_valid = hold_owner || pick_valid;

    // Continuing the current burst extends the count; any new winner
    // starts a fresh burst at one beat.
    assign next_cnt = (locked && (grant_idx == owner)) ? beat_cnt + CNT_W'(1)
                                                       : CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            owner    <= '0;
            locked   <= 1'b0;
            beat_cnt <= '0;
        end else if (xfer) begin
            owner <= grant_idx;
            if (next_cnt == CNT_W'(MAX_BURST)) begin
                locked   <= 1'b0;
                beat_cnt <= '0;
            end else begin
                locked   <= 1'b1;
                beat_cnt <= next_cnt;
            end
        end else if (load_en && locked && !valid_i[owner]) begin
            // Owner went idle with nobody else to take over this cycle.
            locked   <= 1'b0;
            beat_cnt <= '0;
        end
    end
`else
    assign grant_idx   = pick_idx;
    assign grant_oh    = pick_oh;
    assign grant_valid = pick_valid;
`endif

    assign xfer    = load_en && grant_valid;
    assign ready_o = load_en ? grant_oh : '0;

    // Output register and round-robin pointer. Reset parks the pointer on
    // the last index so requester 0 is examined first.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            src_o   <= '0;
            rr_ptr  <= IDX_W'(NUM_REQ - 1);
        end else if (load_en) begin
            valid_o <= xfer;
            if (xfer) begin
                data_o <= req_data[grant_idx];
                src_o  <= grant_idx;
                rr_ptr <= grant_idx;
            end
        end
    end

endmodule : fifo_rr_arbiter
`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rr_arbiter
//  Description : Scoreboard bench for fifo_rr_arbiter (NUM_REQ=4,
//                DATA_WIDTH=11, MAX_BURST=4). Directed producer queues feed
//                the requesters; the expected beat order for each scenario
//                is pushed up front and a monitor pops it as the FIFO side
//                consumes beats. Expected orders follow FIFO_ARB_BURST_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;

    localparam int DW = 11;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int IW = 2;

    logic               clk;
    logic               rst_n_i;
    logic [NR*DW-1:0]   data_i;
    logic [NR-1:0]      valid_i;
    logic [NR-1:0]      ready_o;
    logic [DW-1:0]      data_o;
    logic               valid_o;
    logic               ready_i;
    logic [IW-1:0]      src_o;

    fifo_rr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .src_o   (src_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int              n_checks  = 0;
    int              n_fail    = 0;
    int              cyc       = 0;
    int              first_pop = -1;
    int              last_pop  = -1;
    logic [IW+DW-1:0] exp_q [$];
    logic [IW+DW-1:0] e;
    logic [DW-1:0]    pq [NR][$];
    logic [DW-1:0]    dummy;
    logic [NR-1:0]    hs = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] word(input int t, input int k, input int i);
        return {3'(t), 2'(k), 6'(i)};
    endfunction

    task automatic exp_push(input int k, input logic [DW-1:0] d);
        exp_q.push_back({IW'(k), d});
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NR; k++) begin
            if (pq[k].size() != 0) begin
                valid_i[k]           = 1'b1;
                data_i[k*DW +: DW]   = pq[k][0];
            end else begin
                valid_i[k]           = 1'b0;
                data_i[k*DW +: DW]   = '0;
            end
        end
    endtask

    // Handshake sampled shortly before each rising edge.
    initial forever begin
        @(negedge clk);
        #3;
        hs = ready_o & valid_i & {NR{rst_n_i}};
    end

    // Producers retire the word that transferred and present the next one.
    initial forever begin
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (hs[k] && pq[k].size() != 0) dummy = pq[k].pop_front();
        end
        hs = '0;
        drive_inputs();
    end

    // Monitor: a beat is consumed whenever valid_o and ready_i are both high.
    initial forever begin
        @(negedge clk);
        #3;
        cyc++;
        if (rst_n_i === 1'b1) begin
            check("ready_o at most one hot", 32'($onehot0(ready_o)), 32'd1);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected beat: got src %0d data 0x%0h, expected no beat", src_o, data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("beat src", 32'(src_o), 32'(e[IW+DW-1:DW]));
                    check("beat data", 32'(data_o), 32'(e[DW-1:0]));
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n_i = 1'b0;
        for (int k = 0; k < NR; k++) pq[k].delete();
        drive_inputs();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #6;
        rst_n_i = 1'b1;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_i = 1'b0;
        ready_i = 1'b1;
        valid_i = '0;
        data_i  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        check("reset data_o", 32'(data_o), 32'h0);
        check("reset valid_o", 32'(valid_o), 32'h0);
        check("reset src_o", 32'(src_o), 32'h0);
        check("reset ready_o", 32'(ready_o), 32'h0);

        // Continuous streaming from all four requesters
        do_reset();
        for (int k = 0; k < NR; k++)
            for (int i = 0; i < 8; i++) pq[k].push_back(word(1, k, i));
        drive_inputs();
`ifdef FIFO_ARB_BURST_LOCK_EN
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NR; k++)
                for (int b = 0; b < 4; b++) exp_push(k, word(1, k, r*4 + b));
`else
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < NR; k++) exp_push(k, word(1, k, i));
`endif
        first_pop = -1;
        wait_empty("stream beats outstanding", 100);
        repeat (4) @(posedge clk);
        check("stream span without gaps", 32'(last_pop - first_pop), 32'd31);

        // Backpressure while a beat is held
        do_reset();
        pq[1].push_back(11'h2A5);
        pq[1].push_back(11'h15A);
        pq[2].push_back(11'h0C3);
        drive_inputs();
`ifdef FIFO_ARB_BURST_LOCK_EN
        exp_push(1, 11'h2A5);
        exp_push(1, 11'h15A);
        exp_push(2, 11'h0C3);
`else
        exp_push(1, 11'h2A5);
        exp_push(2, 11'h0C3);
        exp_push(1, 11'h15A);
`endif
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #3;
            check("stall valid_o", 32'(valid_o), 32'h1);
            check("stall data_o", 32'(data_o), 32'h2A5);
            check("stall src_o", 32'(src_o), 32'h1);
            check("stall ready_o", 32'(ready_o), 32'h0);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        wait_empty("backpressure beats outstanding", 30);
        repeat (4) @(posedge clk);

        // Owner drops valid mid-burst
        do_reset();
        for (int i = 0; i < 2; i++) pq[1].push_back(word(3, 1, i));
        for (int i = 0; i < 4; i++) pq[2].push_back(word(3, 2, i));
        for (int i = 0; i < 4; i++) pq[3].push_back(word(3, 3, i));
        drive_inputs();
`ifdef FIFO_ARB_BURST_LOCK_EN
        for (int i = 0; i < 2; i++) exp_push(1, word(3, 1, i));
        for (int i = 0; i < 4; i++) exp_push(2, word(3, 2, i));
        for (int i = 0; i < 4; i++) exp_push(3, word(3, 3, i));
`else
        for (int i = 0; i < 2; i++) begin
            exp_push(1, word(3, 1, i));
            exp_push(2, word(3, 2, i));
            exp_push(3, word(3, 3, i));
        end
        for (int i = 2; i < 4; i++) begin
            exp_push(2, word(3, 2, i));
            exp_push(3, word(3, 3, i));
        end
`endif
        wait_empty("owner-drop beats outstanding", 40);
        repeat (4) @(posedge clk);

        // Asynchronous reset during beat 3 of requester 2
        do_reset();
        for (int k = 0; k < NR; k++)
            for (int i = 0; i < 8; i++) pq[k].push_back(word(4, k, i));
        drive_inputs();
`ifdef FIFO_ARB_BURST_LOCK_EN
        for (int k = 0; k < 2; k++)
            for (int b = 0; b < 4; b++) exp_push(k, word(4, k, b));
        exp_push(2, word(4, 2, 0));
        exp_push(2, word(4, 2, 1));
`else
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NR; k++) exp_push(k, word(4, k, i));
        exp_push(0, word(4, 0, 2));
        exp_push(1, word(4, 1, 2));
`endif
        wait_empty("pre-reset beats outstanding", 40);
        #1;
        check("beat before reset src_o", 32'(src_o), 32'h2);
        check("beat before reset data_o", 32'(data_o), 32'(word(4, 2, 2)));
        #1;
        rst_n_i = 1'b0;
        #1;
        check("async reset valid_o", 32'(valid_o), 32'h0);
        check("async reset data_o", 32'(data_o), 32'h0);
        check("async reset src_o", 32'(src_o), 32'h0);
        for (int k = 0; k < NR; k++) begin
            pq[k].delete();
            pq[k].push_back(word(5, k, 0));
        end
        drive_inputs();
        for (int k = 0; k < NR; k++) exp_push(k, word(5, k, 0));
        #4;
        rst_n_i = 1'b1;
        wait_empty("post-reset beats outstanding", 30);
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_rr_arbiter
`default_nettype wire

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

- Round-robin arbiter that merges `NUM_REQ` Avalon-ST producers into the single write port of a register FIFO.
- Grants one requester per beat; with burst locking compiled in, holds a grant for up to `MAX_BURST` consecutive beats.
- Presents the winning beat through one registered output stage with full throughput.
- Sits directly upstream of the FIFO `data_i/valid_i/ready_o` port.

## Interface

Parameters:
- `DATA_WIDTH`, 11, beat width.
- `NUM_REQ`, 4, number of requesters (≥2).
- `MAX_BURST`, 4, maximum consecutive beats per grant (≥1); used only with burst locking.

Ports:
- `clk_i` in 1: single clock, all logic on rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `data_i` in `NUM_REQ*DATA_WIDTH`: packed requester data; requester k occupies `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `valid_i` in `NUM_REQ`: per-requester valid.
- `ready_o` out `NUM_REQ`: per-requester ready; at most one bit high.
- `data_o` out `DATA_WIDTH`: registered beat to the FIFO.
- `valid_o` out 1: `data_o` holds a beat.
- `ready_i` in 1: FIFO ready (its `ready_o`).
- `src_o` out `$clog2(NUM_REQ)`: registered index of the requester that supplied `data_o`.

## Operation

Internal state:
- `rr_ptr`: index of the last requester that transferred.
- `owner`, `locked`.
- `beat_cnt`: width `$clog2(MAX_BURST+1)`.
- Output register: `data_o`, `valid_o`, `src_o`.

Load and grant:
- `load_en = !valid_o || ready_i`.
- Grant selection, combinational from current state:
  - If `locked && valid_i[owner]`: grant `owner`.
  - Otherwise: grant the first k with `valid_i[k]=1`, scanning `rr_ptr+1, rr_ptr+2, …` modulo `NUM_REQ`.
  - No valid requester: no grant.
- `ready_o[k] = load_en && grant==k`. A transfer from k occurs when `ready_o[k] && valid_i[k]`.

On a transfer from k:
- `data_o <= data_i[k]`, `src_o <= k`, `valid_o <= 1`, `rr_ptr <= k`.
- If k==`owner` and `locked`: `beat_cnt+1`; otherwise `owner <= k`, count restarts at 1.
- When the new count equals `MAX_BURST`: `locked <= 0`, `beat_cnt <= 0`. Otherwise `locked <= 1`.

Other cycles:
- `load_en` with no transfer: `valid_o <= 0`; `data_o` and `src_o` hold.
- `load_en && locked && !valid_i[owner]`: `locked <= 0`, `beat_cnt <= 0`. This is the same cycle another requester may win.
- `!load_en`: all state holds. `data_o`, `valid_o` and `src_o` remain stable until `ready_i`.

## Timing

- Reset values: `data_o=0`, `valid_o=0`, `src_o=0`, `rr_ptr=NUM_REQ-1` (requester 0 wins first), `owner=0`, `locked=0`, `beat_cnt=0`.
- `ready_o` is derived from these: all zero while no `valid_i` is asserted.
- Latency: a beat accepted at edge n appears on `data_o` with `valid_o=1` after edge n.
- Throughput: one beat per cycle whenever `ready_i=1`.
- Simultaneous FIFO drain and new accept in one cycle: both occur; no bubble and no duplicate beat.
- `ready_o` depends combinationally on `valid_i`, `ready_i` and state.
- `data_o`, `valid_o` and `src_o` are register outputs.
- Reset asserted mid-burst clears all state and outputs immediately, without waiting for a clock edge. After deassertion, arbitration restarts from requester 0.
- `rr_ptr` wrap: `NUM_REQ-1` → 0.
- `MAX_BURST=1` behaves identically to locking disabled.

## Configuration

- Macro: `FIFO_ARB_BURST_LOCK_EN`.
- Defined: burst locking as described above.
- Undefined: `owner`, `locked` and `beat_cnt` are not implemented. Every grant comes from the round-robin scan, so requesters alternate per beat. `MAX_BURST` is ignored.

## Structure

- Shared package `fifo_arb_pkg`:
  - Index width constant `$clog2(NUM_REQ)`.
  - Count width constant `$clog2(MAX_BURST+1)`.
  - Modulo-increment helper function for `rr_ptr`.
- Sub-module `rr_priority_picker`:
  - Purely combinational; inputs are the request vector and the start index.
  - Outputs a one-hot grant and its index.
  - Instantiated once.

## Test plan

Benches use `NUM_REQ=4`, `DATA_WIDTH=11`, `MAX_BURST=4`.

- **Reset:** assert `rst_n_i=0` with all `valid_i=0` → `data_o=0`, `valid_o=0`, `src_o=0`, `ready_o=4'b0000`.
- **Lock disabled:** all four requesters valid continuously, `ready_i=1` → `src_o` sequence 0,1,2,3,0,1,… with one beat per cycle and no gaps.
- **Lock enabled:** same stimulus → `src_o` sequence 0,0,0,0,1,1,1,1,2,…; each requester's data in order.
- **Backpressure:** `ready_i=0` for 3 cycles while `valid_o=1` and `data_o=11'h2A5` → `data_o`/`src_o` stable and `ready_o=0000`. Then `ready_i=1` → no beat lost or duplicated (scoreboard count matches).
- **Owner drops valid:** lock enabled, requester 1 drops `valid_i[1]` after 2 beats while 2 and 3 are valid → next beat is from 2, and 2 then receives its full 4-beat burst.
- **Async reset mid-burst:** assert `rst_n_i` low for half a cycle during beat 3 of requester 2 → `valid_o` drops immediately. After release with all requesters valid, the first beat comes from requester 0.
